// File: rtl/la_rle_compressor.sv
// -----------------------------------------------------------------------------
// la_rle_compressor
//
// Run-length compressor for a logic-analyser pod. Each cycle one SAMPLE_WIDTH
// word arrives (8 channels x 8 time-ordered sub-samples). While capture_en is
// high, consecutive identical words are merged into a single record
// {word, run length}. The falling edge of capture_en flushes the open run as a
// record tagged rec_last. Records are queued in a FIFO_DEPTH-entry buffer. If
// the buffer is full, the record is dropped, overflow is set and drop_count is
// incremented; both are cleared when the next capture starts.
//
// Parameters
//   SAMPLE_WIDTH : bits per input word (default 64)
//   LEN_WIDTH    : run-length field width, MAXLEN = 2^LEN_WIDTH-1 (default 32)
//   FIFO_DEPTH   : record buffer depth, power of 2, at least 2 (default 8)
//
// Ports
//   clk_250mhz  in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   samples     in   one sample word per cycle
//   capture_en  in   level: high = compress, falling edge = flush
//   rec_valid   out  a record is at the buffer head
//   rec_ready   in   consumer takes the head record when rec_valid & rec_ready
//   rec_data    out  word value of the head record's run
//   rec_len     out  number of cycles that word persisted (1..MAXLEN)
//   rec_last    out  head record is the flush record of a capture
//   overflow    out  sticky: a record was dropped in the current capture
//   drop_count  out  records dropped in the current capture, saturating
// -----------------------------------------------------------------------------
module la_rle_compressor #(
    parameter int SAMPLE_WIDTH = 64,
    parameter int LEN_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk_250mhz,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] samples,
    input  logic                    capture_en,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [SAMPLE_WIDTH-1:0] rec_data,
    output logic [LEN_WIDTH-1:0]    rec_len,
    output logic                    rec_last,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = {LEN_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]     PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Saturating increment for the 16-bit drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = value;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

    // ---------------------------------------------------------------------
    // Signals
    // ---------------------------------------------------------------------
    state_t                  state_r;
    state_t                  state_next_s;

    logic [SAMPLE_WIDTH-1:0] cur_word_r;
    logic [LEN_WIDTH-1:0]    run_len_r;

    logic                    capture_start_s;  // IDLE -> RUN transition
    logic                    load_s;           // start a new run with samples
    logic                    extend_s;         // lengthen the open run
    logic                    push_req_s;       // a record is produced this cycle
    logic                    push_last_s;      // that record is the flush record

    logic [SAMPLE_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]    mem_len_r  [FIFO_DEPTH];
    logic                    mem_last_r [FIFO_DEPTH];

    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic [PTR_W-1:0]        wr_ptr_next_s;
    logic [PTR_W-1:0]        rd_ptr_next_s;
    logic [CNT_W-1:0]        count_next_s;

    logic                    pop_s;
    logic                    full_s;
    logic                    push_ok_s;
    logic                    push_drop_s;

    logic                    rec_valid_r;
    logic [SAMPLE_WIDTH-1:0] rec_data_r;
    logic [LEN_WIDTH-1:0]    rec_len_r;
    logic                    rec_last_r;
    logic                    overflow_r;
    logic [15:0]             drop_count_r;

    logic [SAMPLE_WIDTH-1:0] head_data_s;
    logic [LEN_WIDTH-1:0]    head_len_s;
    logic                    head_last_s;

    // ---------------------------------------------------------------------
    // Capture state machine
    // ---------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk_250mhz) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: capture_en alone decides IDLE/RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_en) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (capture_en) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: decide whether the run is extended, closed, or flushed.
    always_comb begin
        capture_start_s = 1'b0;
        load_s          = 1'b0;
        extend_s        = 1'b0;
        push_req_s      = 1'b0;
        push_last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (capture_en) begin
                    capture_start_s = 1'b1;
                    load_s          = 1'b1;
                end else begin
                    load_s          = 1'b0;
                end
            end
            ST_RUN: begin
                if (capture_en) begin
                    // A saturated run is closed even if the word repeats.
                    if ((samples == cur_word_r) && (run_len_r != LEN_MAX)) begin
                        extend_s   = 1'b1;
                    end else begin
                        push_req_s = 1'b1;
                        load_s     = 1'b1;
                    end
                end else begin
                    // Flush; the sample presented this cycle is discarded.
                    push_req_s  = 1'b1;
                    push_last_s = 1'b1;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Open-run registers: current word and its length so far.
    always_ff @(posedge clk_250mhz) begin
        if (rst) begin
            cur_word_r <= {SAMPLE_WIDTH{1'b0}};
            run_len_r  <= {LEN_WIDTH{1'b0}};
        end else if (load_s) begin
            cur_word_r <= samples;
            run_len_r  <= LEN_ONE;
        end else if (extend_s) begin
            run_len_r  <= run_len_r + LEN_ONE;
        end else begin
            run_len_r  <= run_len_r;
        end
    end

    // ---------------------------------------------------------------------
    // Record buffer
    // ---------------------------------------------------------------------

    // A full buffer still takes a record when the head leaves on the same
    // edge. rec_valid_r is low whenever the buffer is empty, so a ready on an
    // empty buffer never counts as a pop.
    always_comb begin
        pop_s       = rec_valid_r & rec_ready;
        full_s      = (count_r == CNT_FULL);
        push_ok_s   = push_req_s & (~full_s | pop_s);
        push_drop_s = push_req_s & ~push_ok_s;
    end

    // Next pointer and occupancy values; pointers wrap modulo FIFO_DEPTH.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (push_ok_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Head of the buffer after this edge. When the slot being written this
    // cycle becomes the head, the record bypasses the storage array.
    always_comb begin
        head_data_s = {SAMPLE_WIDTH{1'b0}};
        head_len_s  = {LEN_WIDTH{1'b0}};
        head_last_s = 1'b0;
        if (count_next_s == CNT_ZERO) begin
            head_data_s = {SAMPLE_WIDTH{1'b0}};
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_data_s = cur_word_r;
            head_len_s  = run_len_r;
            head_last_s = push_last_s;
        end else begin
            head_data_s = mem_data_r[rd_ptr_next_s];
            head_len_s  = mem_len_r[rd_ptr_next_s];
            head_last_s = mem_last_r[rd_ptr_next_s];
        end
    end

    // Record storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk_250mhz) begin
        if (push_ok_s) begin
            mem_data_r[wr_ptr_r] <= cur_word_r;
            mem_len_r[wr_ptr_r]  <= run_len_r;
            mem_last_r[wr_ptr_r] <= push_last_s;
        end else begin
            mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and the registered head outputs.
    always_ff @(posedge clk_250mhz) begin
        if (rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_ZERO;
            rec_valid_r <= 1'b0;
            rec_data_r  <= {SAMPLE_WIDTH{1'b0}};
            rec_len_r   <= {LEN_WIDTH{1'b0}};
            rec_last_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            rec_valid_r <= (count_next_s != CNT_ZERO);
            rec_data_r  <= head_data_s;
            rec_len_r   <= head_len_s;
            rec_last_r  <= head_last_s;
        end
    end

    // Drop tracking: cleared when a capture starts, sticky within it.
    always_ff @(posedge clk_250mhz) begin
        if (rst) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else if (capture_start_s) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else if (push_drop_s) begin
            overflow_r   <= 1'b1;
            drop_count_r <= sat_inc16(drop_count_r);
        end else begin
            overflow_r   <= overflow_r;
        end
    end

    assign rec_valid  = rec_valid_r;
    assign rec_data   = rec_data_r;
    assign rec_len    = rec_len_r;
    assign rec_last   = rec_last_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_la_rle_compressor.sv
// -----------------------------------------------------------------------------
// tb_la_rle_compressor
//
// Directed bench for la_rle_compressor. A default-parameter instance carries
// most scenarios; a LEN_WIDTH=4 instance shares the same inputs so run-length
// saturation can be observed. Records handed over to the consumer are logged
// at the falling edge and compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_la_rle_compressor;

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] len;
        logic        last;
    } rec_t;

    logic        clk_250mhz = 1'b0;
    logic        rst;
    logic [63:0] samples;
    logic        capture_en;
    logic        rec_ready;

    logic        rec_valid;
    logic [63:0] rec_data;
    logic [31:0] rec_len;
    logic        rec_last;
    logic        overflow;
    logic [15:0] drop_count;

    logic        s_rec_valid;
    logic [63:0] s_rec_data;
    logic [3:0]  s_rec_len;
    logic        s_rec_last;
    logic        s_overflow;
    logic [15:0] s_drop_count;

    rec_t        log_q[$];
    rec_t        slog_q[$];

    int          checks = 0;
    int          errors = 0;

    always #2 clk_250mhz = ~clk_250mhz;

    la_rle_compressor dut (
        .clk_250mhz (clk_250mhz),
        .rst        (rst),
        .samples    (samples),
        .capture_en (capture_en),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .rec_len    (rec_len),
        .rec_last   (rec_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    la_rle_compressor #(.LEN_WIDTH(4)) dut_short (
        .clk_250mhz (clk_250mhz),
        .rst        (rst),
        .samples    (samples),
        .capture_en (capture_en),
        .rec_valid  (s_rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (s_rec_data),
        .rec_len    (s_rec_len),
        .rec_last   (s_rec_last),
        .overflow   (s_overflow),
        .drop_count (s_drop_count)
    );

    // Log every record that will be taken on the coming rising edge.
    always @(negedge clk_250mhz) begin
        if (!rst && rec_valid && rec_ready) begin
            log_q.push_back({rec_data, rec_len, rec_last});
        end
        if (!rst && s_rec_valid && rec_ready) begin
            slog_q.push_back({s_rec_data, 28'd0, s_rec_len, s_rec_last});
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_250mhz);
            #1;
        end
    endtask

    function automatic rec_t get_main(input int idx);
        rec_t r = '0;
        if (idx < log_q.size()) r = log_q[idx];
        return r;
    endfunction

    function automatic rec_t get_short(input int idx);
        rec_t r = '0;
        if (idx < slog_q.size()) r = slog_q[idx];
        return r;
    endfunction

    task automatic check_rec(input string tag, input rec_t r, input logic [63:0] d,
                             input logic [31:0] l, input logic lst);
        check({tag, ".data"}, r.data, d);
        check({tag, ".len"},  {32'd0, r.len}, {32'd0, l});
        check({tag, ".last"}, {63'd0, r.last}, {63'd0, lst});
    endtask

    logic [63:0] seq [6];
    int          last_seen;

    initial begin
        rst        = 1'b1;
        capture_en = 1'b0;
        rec_ready  = 1'b1;
        samples    = 64'd0;
        tick(3);

        // Reset state
        check("rst.rec_valid",  {63'd0, rec_valid}, 64'd0);
        check("rst.rec_data",   rec_data, 64'd0);
        check("rst.rec_len",    {32'd0, rec_len}, 64'd0);
        check("rst.rec_last",   {63'd0, rec_last}, 64'd0);
        check("rst.overflow",   {63'd0, overflow}, 64'd0);
        check("rst.drop_count", {48'd0, drop_count}, 64'd0);

        // Constant word for 10 cycles, then flush
        log_q.delete();
        slog_q.delete();
        rst        = 1'b0;
        samples    = 64'hA5;
        capture_en = 1'b1;
        tick(10);
        check("const.no_push_during_run", {63'd0, rec_valid}, 64'd0);
        capture_en = 1'b0;
        tick(1);
        check("const.latency_valid", {63'd0, rec_valid}, 64'd1);
        check("const.head_len", {32'd0, rec_len}, 64'd10);
        tick(3);
        check("const.count", 64'(log_q.size()), 64'd1);
        check_rec("const.r0", get_main(0), 64'hA5, 32'd10, 1'b1);
        check("const.overflow", {63'd0, overflow}, 64'd0);

        // Runs 1,1,1,2,2,3
        log_q.delete();
        slog_q.delete();
        seq = '{64'd1, 64'd1, 64'd1, 64'd2, 64'd2, 64'd3};
        capture_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            samples = seq[i];
            tick(1);
        end
        capture_en = 1'b0;
        tick(4);
        check("runs.count", 64'(log_q.size()), 64'd3);
        check_rec("runs.r0", get_main(0), 64'd1, 32'd3, 1'b0);
        check_rec("runs.r1", get_main(1), 64'd2, 32'd2, 1'b0);
        check_rec("runs.r2", get_main(2), 64'd3, 32'd1, 1'b1);

        // 20 identical words: LEN_WIDTH=4 instance splits at 15
        log_q.delete();
        slog_q.delete();
        samples    = 64'h5A5A;
        capture_en = 1'b1;
        tick(20);
        capture_en = 1'b0;
        tick(4);
        check("sat.short_count", 64'(slog_q.size()), 64'd2);
        check_rec("sat.s0", get_short(0), 64'h5A5A, 32'd15, 1'b0);
        check_rec("sat.s1", get_short(1), 64'h5A5A, 32'd5, 1'b1);
        check("sat.main_count", 64'(log_q.size()), 64'd1);
        check_rec("sat.m0", get_main(0), 64'h5A5A, 32'd20, 1'b1);

        // Stalled consumer, 12 distinct words then flush: 8 kept, 4 dropped
        log_q.delete();
        slog_q.delete();
        rec_ready  = 1'b0;
        capture_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            samples = 64'd16 + 64'(i);
            tick(1);
        end
        capture_en = 1'b0;
        tick(1);
        check("ovf.drop_count", {48'd0, drop_count}, 64'd4);
        check("ovf.overflow",   {63'd0, overflow}, 64'd1);
        check("ovf.rec_valid",  {63'd0, rec_valid}, 64'd1);
        check("ovf.head_data",  rec_data, 64'd16);
        tick(2);
        check("ovf.head_stable", rec_data, 64'd16);
        check("ovf.head_last",  {63'd0, rec_last}, 64'd0);
        check("ovf.nothing_taken", 64'(log_q.size()), 64'd0);
        rec_ready = 1'b1;
        tick(12);
        check("ovf.count", 64'(log_q.size()), 64'd8);
        last_seen = 0;
        for (int i = 0; i < 8; i++) begin
            check("ovf.data", get_main(i).data, 64'd16 + 64'(i));
            check("ovf.len",  {32'd0, get_main(i).len}, 64'd1);
            last_seen += int'(get_main(i).last);
        end
        check("ovf.no_last", 64'(last_seen), 64'd0);
        check("ovf.sticky", {63'd0, overflow}, 64'd1);
        check("ovf.drained", {63'd0, rec_valid}, 64'd0);

        // Full buffer with a pop on the same edge as a push
        log_q.delete();
        slog_q.delete();
        rec_ready  = 1'b0;
        capture_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            samples = 64'd32 + 64'(i);
            tick(1);
        end
        check("full.cleared_overflow", {63'd0, overflow}, 64'd0);
        check("full.cleared_drops", {48'd0, drop_count}, 64'd0);
        samples   = 64'd41;
        rec_ready = 1'b1;
        tick(1);
        check("full.push_pop_drops", {48'd0, drop_count}, 64'd0);
        check("full.push_pop_overflow", {63'd0, overflow}, 64'd0);
        rec_ready  = 1'b0;
        capture_en = 1'b0;
        tick(1);
        check("full.flush_dropped", {48'd0, drop_count}, 64'd1);
        check("full.flush_overflow", {63'd0, overflow}, 64'd1);
        rec_ready = 1'b1;
        tick(12);
        check("full.count", 64'(log_q.size()), 64'd9);
        check_rec("full.r0", get_main(0), 64'd32, 32'd1, 1'b0);
        check_rec("full.r1", get_main(1), 64'd33, 32'd1, 1'b0);
        check_rec("full.r8", get_main(8), 64'd40, 32'd1, 1'b0);

        // Reset in the middle of a capture with 2 records buffered
        log_q.delete();
        slog_q.delete();
        rec_ready  = 1'b0;
        capture_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samples = 64'd1 + 64'(i);
            tick(1);
        end
        check("mrst.buffered", {63'd0, rec_valid}, 64'd1);
        rst = 1'b1;
        tick(1);
        check("mrst.rec_valid", {63'd0, rec_valid}, 64'd0);
        check("mrst.overflow",  {63'd0, overflow}, 64'd0);
        check("mrst.rec_data",  rec_data, 64'd0);
        rst        = 1'b0;
        capture_en = 1'b0;
        rec_ready  = 1'b1;
        tick(5);
        check("mrst.no_records", 64'(log_q.size()), 64'd0);
        check("mrst.still_empty", {63'd0, rec_valid}, 64'd0);

        // Capture starts on the first edge after reset releases
        log_q.delete();
        slog_q.delete();
        rst        = 1'b1;
        capture_en = 1'b1;
        samples    = 64'd77;
        tick(1);
        rst = 1'b0;
        tick(3);
        capture_en = 1'b0;
        tick(4);
        check("rstcap.count", 64'(log_q.size()), 64'd1);
        check_rec("rstcap.r0", get_main(0), 64'd77, 32'd3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
